parity_frame_rx: RTL and testbench

//   Serial frame receiver and parity checker; receiving end of the XNOR/XOR parity link.

---
 rtl/parity_frame_rx.sv | 128 ++++++++++++
 tb/tb_parity_frame_rx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_rx.sv
// Serial frame receiver with parity and framing checks.
// Frame on rx, LSB first: start(0), DATA_W data bits, parity bit, stop(1).
// rx is only looked at on clk edges where bit_en is high; otherwise all state holds.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | line idle, waiting for a low sample (start bit)
// DATA     | collecting data bits into shift_q, indexed by cnt_q
// PARITY   | capturing the received parity bit
// STOP     | sampling stop bit, publishing data and error flags
// WAIT_HI  | stop bit was low; wait for the line to return high
module parity_frame_rx #(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              rx,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int                CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic              PAR_ODD  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DATA    = 3'd1,
    S_PARITY  = 3'd2,
    S_STOP    = 3'd3,
    S_WAIT_HI = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_q, par_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                data_valid_q, data_valid_d;
  logic                parity_err_q, parity_err_d;
  logic                frame_err_q, frame_err_d;

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Next-state and datapath update, gated by the bit strobe.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    data_out_d   = data_out_q;
    // data_valid drops on the next clk regardless of bit_en so the pulse is one cycle.
    data_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    if (bit_en) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end
        end
        S_DATA: begin
          // Loop-based write keeps the index within the shift register range.
          for (int i = 0; i < DATA_W; i++) begin
            if (cnt_q == CNT_W'(i)) shift_d[i] = rx;
          end
          if (cnt_q == CNT_LAST) begin
            state_d = S_PARITY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_PARITY: begin
          par_d   = rx;
          state_d = S_STOP;
        end
        S_STOP: begin
          data_out_d   = shift_q;
          data_valid_d = 1'b1;
          parity_err_d = ((^{shift_q, par_q}) != PAR_ODD);
          frame_err_d  = !rx;
          state_d      = rx ? S_IDLE : S_WAIT_HI;
        end
        S_WAIT_HI: begin
          // A line stuck low after a bad stop bit is not a new start bit.
          if (rx) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx: an even-parity instance driven every
// cycle and an odd-parity instance driven with sparse strobes.
module tb_parity_frame_rx;

  logic       clk;
  logic       rst_n;
  logic       bit_en, rx;
  logic [7:0] data_out;
  logic       data_valid, parity_err, frame_err, busy;
  logic       be2, rx2;
  logic [7:0] data_out2;
  logic       data_valid2, parity_err2, frame_err2, busy2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  parity_frame_rx #(.DATA_W(8), .PARITY_ODD(0)) dut (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx(rx),
    .data_out(data_out), .data_valid(data_valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  parity_frame_rx #(.DATA_W(8), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .bit_en(be2), .rx(rx2),
    .data_out(data_out2), .data_valid(data_valid2),
    .parity_err(parity_err2), .frame_err(frame_err2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    rx = b; bit_en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  // Three idle cycles with the line inverted, then one strobe carrying b.
  task automatic sparse_bit(input logic b);
    be2 = 1'b0; rx2 = ~b;
    repeat (3) @(posedge clk);
    #1;
    rx2 = b; be2 = 1'b1;
    @(posedge clk); #1;
    be2 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bit_en = 1'b0; rx = 1'b1; be2 = 1'b0; rx2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", data_out); end
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL reset_dv: got %b want 0", data_valid); end
    n_cmp++; if ({parity_err, frame_err} !== 2'b00) begin n_err++; $display("FAIL reset_errs: got %b want 00", {parity_err, frame_err}); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({busy2, data_valid2, data_out2} !== 10'd0) begin n_err++; $display("FAIL reset_odd: got %h want 0", {busy2, data_valid2, data_out2}); end
    rst_n = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  task automatic test_good_frame;
    logic [7:0] d;
    d = 8'hA5;
    send_bit(1'b0);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL t1_busy_start: got %b want 1", busy); end
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(1'b0);
    n_cmp++; if ({busy, data_valid} !== 2'b10) begin n_err++; $display("FAIL t1_before_stop: got %b want 10", {busy, data_valid}); end
    send_bit(1'b1);
    n_cmp++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL t1_dv: got %b want 1", data_valid); end
    n_cmp++; if (data_out !== 8'hA5) begin n_err++; $display("FAIL t1_data: got %h want a5", data_out); end
    n_cmp++; if ({parity_err, frame_err} !== 2'b00) begin n_err++; $display("FAIL t1_errs: got %b want 00", {parity_err, frame_err}); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t1_busy_end: got %b want 0", busy); end
    send_bit(1'b1);
    n_cmp++; if ({data_valid, data_out} !== 9'h0A5) begin n_err++; $display("FAIL t1_pulse_hold: got %h want 0a5", {data_valid, data_out}); end
  endtask

  task automatic test_parity_err;
    send_frame(8'hA5, 1'b1, 1'b1);
    n_cmp++; if ({data_valid, data_out} !== 9'h1A5) begin n_err++; $display("FAIL t2_dv_data: got %h want 1a5", {data_valid, data_out}); end
    n_cmp++; if ({parity_err, frame_err} !== 2'b10) begin n_err++; $display("FAIL t2_errs: got %b want 10", {parity_err, frame_err}); end
    send_bit(1'b1);
    n_cmp++; if ({data_valid, parity_err} !== 2'b01) begin n_err++; $display("FAIL t2_after: got %b want 01", {data_valid, parity_err}); end
  endtask

  task automatic test_frame_err;
    send_frame(8'h3C, 1'b0, 1'b0);
    n_cmp++; if ({data_valid, data_out} !== 9'h13C) begin n_err++; $display("FAIL t3_dv_data: got %h want 13c", {data_valid, data_out}); end
    n_cmp++; if ({parity_err, frame_err, busy} !== 3'b011) begin n_err++; $display("FAIL t3_errs_busy: got %b want 011", {parity_err, frame_err, busy}); end
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b0);
      n_cmp++; if ({busy, data_valid} !== 2'b10) begin n_err++; $display("FAIL t3_wait_hi[%0d]: got %b want 10", i, {busy, data_valid}); end
    end
    send_bit(1'b1);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t3_recover_busy: got %b want 0", busy); end
    send_frame(8'h0F, 1'b0, 1'b1);
    n_cmp++; if ({data_valid, data_out} !== 9'h10F) begin n_err++; $display("FAIL t3_next_data: got %h want 10f", {data_valid, data_out}); end
    n_cmp++; if ({parity_err, frame_err} !== 2'b00) begin n_err++; $display("FAIL t3_next_errs: got %b want 00", {parity_err, frame_err}); end
    send_bit(1'b1);
  endtask

  task automatic test_odd_sparse;
    logic [1:0] p_tab;
    logic [1:0] e_tab;
    p_tab = 2'b01;
    e_tab = 2'b10;
    // A low line without strobes must not start a frame.
    be2 = 1'b0; rx2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL t4_no_strobe: got %b want 0", busy2); end
    for (int f = 0; f < 2; f++) begin
      sparse_bit(1'b0);
      n_cmp++; if (busy2 !== 1'b1) begin n_err++; $display("FAIL t4_start[%0d]: got %b want 1", f, busy2); end
      for (int i = 0; i < 8; i++) sparse_bit(1'b0);
      sparse_bit(p_tab[f]);
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if ({busy2, data_valid2} !== 2'b10) begin n_err++; $display("FAIL t4_hold[%0d]: got %b want 10", f, {busy2, data_valid2}); end
      rx2 = 1'b1; be2 = 1'b1;
      @(posedge clk); #1;
      be2 = 1'b0;
      n_cmp++; if ({data_valid2, data_out2, busy2} !== 10'b1_00000000_0) begin n_err++; $display("FAIL t4_dv[%0d]: got %b want 1000000000", f, {data_valid2, data_out2, busy2}); end
      n_cmp++; if ({parity_err2, frame_err2} !== {e_tab[f], 1'b0}) begin n_err++; $display("FAIL t4_errs[%0d]: got %b want %b0", f, {parity_err2, frame_err2}, e_tab[f]); end
      @(posedge clk); #1;
      n_cmp++; if ({data_valid2, parity_err2} !== {1'b0, e_tab[f]}) begin n_err++; $display("FAIL t4_pulse[%0d]: got %b want 0%b", f, {data_valid2, parity_err2}, e_tab[f]); end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    logic       seen_dv;
    d = 8'hC3;
    seen_dv = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL t5_async_data: got %h want 00", data_out); end
    n_cmp++; if ({data_valid, parity_err, frame_err, busy} !== 4'b0000) begin n_err++; $display("FAIL t5_async_flags: got %b want 0000", {data_valid, parity_err, frame_err, busy}); end
    n_cmp++; if ({busy2, data_out2} !== 9'h000) begin n_err++; $display("FAIL t5_async_odd: got %h want 000", {busy2, data_out2}); end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send_bit(1'b1);
      seen_dv = seen_dv | data_valid | busy;
    end
    n_cmp++; if (seen_dv !== 1'b0) begin n_err++; $display("FAIL t5_no_frame: got %b want 0", seen_dv); end
    send_frame(8'h81, 1'b0, 1'b1);
    n_cmp++; if ({data_valid, data_out} !== 9'h181) begin n_err++; $display("FAIL t5_next_data: got %h want 181", {data_valid, data_out}); end
    n_cmp++; if ({parity_err, frame_err} !== 2'b00) begin n_err++; $display("FAIL t5_next_errs: got %b want 00", {parity_err, frame_err}); end
    send_bit(1'b1);
  endtask

  task automatic test_back_to_back;
    int t1;
    send_frame(8'h55, 1'b0, 1'b1);
    t1 = cyc;
    n_cmp++; if ({data_valid, data_out} !== 9'h155) begin n_err++; $display("FAIL t6_first: got %h want 155", {data_valid, data_out}); end
    send_frame(8'hAA, 1'b0, 1'b1);
    n_cmp++; if ({data_valid, data_out} !== 9'h1AA) begin n_err++; $display("FAIL t6_second: got %h want 1aa", {data_valid, data_out}); end
    n_cmp++; if ((cyc - t1) !== 11) begin n_err++; $display("FAIL t6_spacing: got %0d want 11", cyc - t1); end
    n_cmp++; if ({parity_err, frame_err} !== 2'b00) begin n_err++; $display("FAIL t6_errs: got %b want 00", {parity_err, frame_err}); end
    send_bit(1'b1);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_frame_err();
    test_odd_sparse();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
